// File: rtl/rob_submit_arbiter_pkg.sv
// Shared definitions for the ROB submit-port arbiter: widths, FSM encoding, helpers.
package rob_submit_arbiter_pkg;

    localparam int ROB_TAG_W   = 4;
    localparam int ROB_DATA_W  = 32;
    localparam int ROB_SIZE    = 16;
    localparam int FLUSH_CNT_W = 4;

    typedef enum logic {
        ARB_RUN   = 1'b0,
        ARB_FLUSH = 1'b1
    } arb_state_e;

    // Pointer width that still works for a single requester.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rob_submit_arbiter_if.sv
// Source-side handshake and ROB submit bus shared by completion sources and the arbiter.
interface rob_submit_arbiter_if
    import rob_submit_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = ROB_TAG_W,
    parameter int DATA_W  = ROB_DATA_W
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*TAG_W-1:0]  req_tag;
    logic [NUM_REQ*DATA_W-1:0] req_val;
    logic [TAG_W-1:0]          submit_tag;
    logic [DATA_W-1:0]         submit_val;
    logic                      submit_valid;

    modport master (
        output req_valid, req_tag, req_val,
        input  req_ready, submit_tag, submit_val, submit_valid
    );

    modport slave (
        input  req_valid, req_tag, req_val,
        output req_ready, submit_tag, submit_val, submit_valid
    );

endinterface

// File: rtl/rob_submit_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr, wrapping.
module rob_submit_arbiter_rr_pick
    import rob_submit_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = ptr_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               any
);

    // Scan from the farthest offset down so the nearest valid requester wins last.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
                grant = '0;
                grant[(int'(rr_ptr) + k) % NUM_REQ] = 1'b1;
                grant_idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rob_submit_arbiter.sv
// Round-robin arbiter sharing the ROB submit port among NUM_REQ completion sources.
// Optional SUBMIT_ARB_PERF_EN adds per-source grant and contention counters.
module rob_submit_arbiter
    import rob_submit_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int TAG_W        = ROB_TAG_W,
    parameter int DATA_W       = ROB_DATA_W,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 predict_fail,
    rob_submit_arbiter_if.slave  bus
`ifdef SUBMIT_ARB_PERF_EN
    ,
    output logic [NUM_REQ*32-1:0] grant_cnt,
    output logic [31:0]           conflict_cnt
`endif
);

    localparam int PTR_W = ptr_w(NUM_REQ);
    localparam logic [FLUSH_CNT_W-1:0] FLUSH_INIT = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [FLUSH_CNT_W-1:0] CNT_ONE    = FLUSH_CNT_W'(1);
    localparam logic [PTR_W-1:0]       PTR_LAST   = PTR_W'(NUM_REQ - 1);
    localparam logic [PTR_W-1:0]       PTR_ONE    = PTR_W'(1);

    arb_state_e             state_q, state_nx;
    logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_nx;
    logic [PTR_W-1:0]       rr_ptr_q;

    logic [NUM_REQ-1:0]     pick_grant;
    logic [PTR_W-1:0]       pick_idx;
    logic                   pick_any;
    logic                   arb_en;
    logic                   grant_go;

    logic [TAG_W-1:0]       tag_p0, tag_p1;
    logic [DATA_W-1:0]      val_p0, val_p1;
    logic                   vld_p1;

    rob_submit_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req_valid (bus.req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q     <= ARB_RUN;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_nx;
            flush_cnt_q <= flush_cnt_nx;
        end
    end

    always_comb begin
        state_nx     = state_q;
        flush_cnt_nx = flush_cnt_q;
        if (rdy_in) begin
            if (predict_fail) begin
                state_nx     = ARB_FLUSH;
                flush_cnt_nx = FLUSH_INIT;
            end else if (state_q == ARB_FLUSH) begin
                if (flush_cnt_q == '0) begin
                    state_nx = ARB_RUN;
                end else begin
                    flush_cnt_nx = flush_cnt_q - CNT_ONE;
                end
            end
        end
    end

    always_comb begin
        arb_en        = rst_in & rdy_in & ~predict_fail & (state_q == ARB_RUN);
        grant_go      = arb_en & pick_any;
        bus.req_ready = arb_en ? pick_grant : '0;
    end

    // p0: select the granted source's tag/value (grant is one-hot).
    always_comb begin
        tag_p0 = '0;
        val_p0 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) begin
                tag_p0 = tag_p0 | bus.req_tag[i*TAG_W +: TAG_W];
                val_p0 = val_p0 | bus.req_val[i*DATA_W +: DATA_W];
            end
        end
    end

    // p1: registered submit toward the ROB; everything freezes while rdy_in is low.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            vld_p1   <= 1'b0;
            tag_p1   <= '0;
            val_p1   <= '0;
            rr_ptr_q <= '0;
        end else if (rdy_in) begin
            if (predict_fail) begin
                vld_p1   <= 1'b0;
                rr_ptr_q <= '0;
            end else if (grant_go) begin
                vld_p1   <= 1'b1;
                tag_p1   <= tag_p0;
                val_p1   <= val_p0;
                rr_ptr_q <= (pick_idx == PTR_LAST) ? '0 : pick_idx + PTR_ONE;
            end else begin
                vld_p1   <= 1'b0;
            end
        end
    end

    assign bus.submit_valid = vld_p1;
    assign bus.submit_tag   = tag_p1;
    assign bus.submit_val   = val_p1;

`ifdef SUBMIT_ARB_PERF_EN
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            grant_cnt    <= '0;
            conflict_cnt <= '0;
        end else if (rdy_in) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_go && pick_grant[i]) begin
                    grant_cnt[i*32 +: 32] <= grant_cnt[i*32 +: 32] + 32'd1;
                end
            end
            if (arb_en && ($countones(bus.req_valid) >= 2)) begin
                conflict_cnt <= conflict_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rob_submit_arbiter.sv
// Vector-table and scoreboard bench for rob_submit_arbiter (NUM_REQ=2, FLUSH_CYCLES=2).
module tb_rob_submit_arbiter;

    localparam int NR = 2;
    localparam int TW = 4;
    localparam int DW = 32;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;
    logic predict_fail;

    always #5 clk_in = ~clk_in;

    rob_submit_arbiter_if #(.NUM_REQ(NR), .TAG_W(TW), .DATA_W(DW)) bus ();

`ifdef SUBMIT_ARB_PERF_EN
    logic [NR*32-1:0] grant_cnt;
    logic [31:0]      conflict_cnt;
`endif

    rob_submit_arbiter #(
        .NUM_REQ      (NR),
        .TAG_W        (TW),
        .DATA_W       (DW),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .predict_fail (predict_fail),
        .bus          (bus)
`ifdef SUBMIT_ARB_PERF_EN
        ,
        .grant_cnt    (grant_cnt),
        .conflict_cnt (conflict_cnt)
`endif
    );

    typedef struct {
        logic          rst;
        logic          rdy;
        logic          pf;
        logic [1:0]    vld;
        logic [TW-1:0] t0;
        logic [DW-1:0] v0;
        logic [TW-1:0] t1;
        logic [DW-1:0] v1;
        logic [1:0]    exp_rdy;
        logic          exp_sv;
        logic [TW-1:0] exp_tag;
        logic [DW-1:0] exp_val;
    } vec_t;

    typedef struct {
        logic          sv;
        logic [TW-1:0] tag;
        logic [DW-1:0] val;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(input logic rst, input logic rdy, input logic pf,
                                input logic [1:0] vld,
                                input logic [TW-1:0] t0, input logic [DW-1:0] v0,
                                input logic [TW-1:0] t1, input logic [DW-1:0] v1,
                                input logic [1:0] er, input logic esv,
                                input logic [TW-1:0] et, input logic [DW-1:0] ev);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.pf = pf; v.vld = vld;
        v.t0 = t0; v.v0 = v0; v.t1 = t1; v.v1 = v1;
        v.exp_rdy = er; v.exp_sv = esv; v.exp_tag = et; v.exp_val = ev;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        rst_in        = v.rst;
        rdy_in        = v.rdy;
        predict_fail  = v.pf;
        bus.req_valid = v.vld;
        bus.req_tag   = {v.t1, v.t0};
        bus.req_val   = {v.v1, v.v0};
        sb_q.push_back('{sv: v.exp_sv, tag: v.exp_tag, val: v.exp_val});
        #3;
        check($sformatf("v%0d_req_ready", idx), 32'(bus.req_ready), 32'(v.exp_rdy));
        @(posedge clk_in);
        #1;
        e = sb_q.pop_front();
        check($sformatf("v%0d_submit_valid", idx), 32'(bus.submit_valid), 32'(e.sv));
        if (e.sv) begin
            check($sformatf("v%0d_submit_tag", idx), 32'(bus.submit_tag), 32'(e.tag));
            check($sformatf("v%0d_submit_val", idx), bus.submit_val, e.val);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int blocked;
        rst_in = 1'b0; rdy_in = 1'b1; predict_fail = 1'b0;
        bus.req_valid = '0; bus.req_tag = '0; bus.req_val = '0;

        // reset with both sources valid, then contention
        vecs.push_back(mk(0,1,0,2'b11, 3,32'h11, 5,32'h22, 2'b00,0,0,0));
        vecs.push_back(mk(0,1,0,2'b11, 3,32'h11, 5,32'h22, 2'b00,0,0,0));
        vecs.push_back(mk(1,1,0,2'b11, 3,32'h11, 5,32'h22, 2'b01,1,3,32'h11));
        vecs.push_back(mk(1,1,0,2'b11, 3,32'h11, 5,32'h22, 2'b10,1,5,32'h22));
        vecs.push_back(mk(1,1,0,2'b11, 3,32'h11, 5,32'h22, 2'b01,1,3,32'h11));
        vecs.push_back(mk(1,1,0,2'b11, 3,32'h11, 5,32'h22, 2'b10,1,5,32'h22));
        // single source back-to-back
        vecs.push_back(mk(1,1,0,2'b10, 0,0, 8,32'h80,  2'b10,1,8,32'h80));
        vecs.push_back(mk(1,1,0,2'b10, 0,0, 9,32'h90,  2'b10,1,9,32'h90));
        vecs.push_back(mk(1,1,0,2'b10, 0,0, 10,32'hA0, 2'b10,1,10,32'hA0));
        vecs.push_back(mk(1,1,0,2'b10, 0,0, 11,32'hB0, 2'b10,1,11,32'hB0));
        vecs.push_back(mk(1,1,0,2'b00, 0,0, 0,0,       2'b00,0,0,0));
        // pause right after grant of tag 7
        vecs.push_back(mk(1,1,0,2'b01, 7,32'h77, 0,0,  2'b01,1,7,32'h77));
        vecs.push_back(mk(1,0,0,2'b10, 0,0, 6,32'h66,  2'b00,1,7,32'h77));
        vecs.push_back(mk(1,0,0,2'b10, 0,0, 6,32'h66,  2'b00,1,7,32'h77));
        vecs.push_back(mk(1,0,0,2'b10, 0,0, 6,32'h66,  2'b00,1,7,32'h77));
        vecs.push_back(mk(1,1,0,2'b10, 0,0, 6,32'h66,  2'b10,1,6,32'h66));
        // flush pulse with both valid
        vecs.push_back(mk(1,1,1,2'b11, 3,32'h11, 5,32'h22, 2'b00,0,0,0));
        vecs.push_back(mk(1,1,0,2'b11, 3,32'h11, 5,32'h22, 2'b00,0,0,0));
        vecs.push_back(mk(1,1,0,2'b11, 3,32'h11, 5,32'h22, 2'b00,0,0,0));
        vecs.push_back(mk(1,1,0,2'b11, 3,32'h11, 5,32'h22, 2'b01,1,3,32'h11));
        vecs.push_back(mk(1,1,0,2'b11, 3,32'h11, 5,32'h22, 2'b10,1,5,32'h22));
        // predict_fail during FLUSH restarts the window
        vecs.push_back(mk(1,1,1,2'b11, 3,32'h11, 5,32'h22, 2'b00,0,0,0));
        vecs.push_back(mk(1,1,0,2'b11, 3,32'h11, 5,32'h22, 2'b00,0,0,0));
        vecs.push_back(mk(1,1,1,2'b11, 3,32'h11, 5,32'h22, 2'b00,0,0,0));
        vecs.push_back(mk(1,1,0,2'b11, 3,32'h11, 5,32'h22, 2'b00,0,0,0));
        vecs.push_back(mk(1,1,0,2'b11, 3,32'h11, 5,32'h22, 2'b00,0,0,0));
        vecs.push_back(mk(1,1,0,2'b11, 3,32'h11, 5,32'h22, 2'b01,1,3,32'h11));
        // predict_fail while paused is ignored
        vecs.push_back(mk(1,0,1,2'b11, 3,32'h11, 5,32'h22, 2'b00,1,3,32'h11));
        vecs.push_back(mk(1,1,0,2'b11, 3,32'h11, 5,32'h22, 2'b10,1,5,32'h22));
        // reset mid-run clears the pointer
        vecs.push_back(mk(1,1,0,2'b11, 3,32'h11, 5,32'h22, 2'b01,1,3,32'h11));
        vecs.push_back(mk(0,1,0,2'b11, 3,32'h11, 5,32'h22, 2'b00,0,0,0));
        vecs.push_back(mk(1,1,0,2'b11, 3,32'h11, 5,32'h22, 2'b01,1,3,32'h11));

        @(posedge clk_in);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // flush window length measured against a bounded wait
        blocked = 0;
        predict_fail  = 1'b1;
        bus.req_valid = 2'b11;
        for (int c = 0; c < 8; c++) begin
            #3;
            if (bus.req_ready !== 2'b00) break;
            blocked++;
            @(posedge clk_in);
            #1;
            predict_fail = 1'b0;
            check("flush_submit_idle", 32'(bus.submit_valid), 32'd0);
        end
        check("flush_blocked_cycles", 32'(blocked), 32'd3);
        check("flush_first_grant", 32'(bus.req_ready), 32'h1);
        @(posedge clk_in);
        #1;
        check("flush_first_tag", 32'(bus.submit_tag), 32'd3);

`ifdef SUBMIT_ARB_PERF_EN
        rst_in = 1'b0;
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        bus.req_valid = 2'b11;
        repeat (10) @(posedge clk_in);
        #1;
        bus.req_valid = 2'b00;
        @(posedge clk_in);
        #1;
        check("perf_conflict_cnt", conflict_cnt, 32'd10);
        check("perf_grant_cnt0", grant_cnt[31:0], 32'd5);
        check("perf_grant_cnt1", grant_cnt[63:32], 32'd5);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
